multi_tick_generator: RTL

- Parametrised, multi-channel successor to the single fixed-rate tick generator.
- Produces NUM_CH independent one-cycle tick strobes, each with a runtime-programmable period (in clk cycles), per-channel enable, periodic/one-shot mode and synchronous restart.
- Sits between the system clock and timing consumers: UART baud ticks, DHT11 bit-timing windows, HC-SR04 trigger/echo timeouts. One instance replaces several fixed-divisor instances.

---
 rtl/multi_tick_generator.sv | 89 ++++++++
 1 files changed

// File: rtl/multi_tick_generator.sv
// NUM_CH independent programmable tick strobes. Each channel has a shadowed
// period register, enable, one-shot mode and a synchronous restart.
module multi_tick_generator #(
  parameter int CLOCK_FREQ  = 100_000_000,
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 24,
  parameter int DEFAULT_DIV = CLOCK_FREQ / 9600
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic                                           wr_en,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] wr_ch,
  input  logic [DIV_W-1:0]                               wr_div,
  input  logic [NUM_CH-1:0]                              ch_en,
  input  logic [NUM_CH-1:0]                              oneshot,
  input  logic [NUM_CH-1:0]                              sync_clr,
  output logic [NUM_CH-1:0]                              tick,
  output logic [NUM_CH-1:0]                              busy
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [DIV_W-1:0] shadow;
    logic [DIV_W-1:0] active;
    logic [DIV_W-1:0] count;
    logic [DIV_W-1:0] last;
    logic             done;
    logic             tick_q;
    logic             busy_q;
    logic             wr_hit;

    // Indices at or above NUM_CH never match any channel, so they are dropped.
    assign wr_hit = wr_en && (wr_ch == CH_W'(i));

    // A programmed period of zero behaves as a period of one.
    always_comb begin
      last = '0;
      if (active != '0) last = active - DIV_W'(1);
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset)       shadow <= DEF_DIV;
      else if (wr_hit) shadow <= wr_div;
    end

    // Active only reloads at period boundaries, so writes never distort a period.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        count  <= '0;
        done   <= 1'b0;
        tick_q <= 1'b0;
        busy_q <= 1'b0;
        active <= DEF_DIV;
      end else if (!ch_en[i]) begin
        count  <= '0;
        done   <= 1'b0;
        tick_q <= 1'b0;
        busy_q <= 1'b0;
        active <= shadow;
      end else if (sync_clr[i]) begin
        count  <= '0;
        done   <= 1'b0;
        tick_q <= 1'b0;
        busy_q <= 1'b1;
        active <= shadow;
      end else if (done) begin
        count  <= '0;
        tick_q <= 1'b0;
        busy_q <= 1'b0;
      end else if (count == last) begin
        count  <= '0;
        tick_q <= 1'b1;
        done   <= oneshot[i];
        busy_q <= ~oneshot[i];
        active <= shadow;
      end else begin
        count  <= count + DIV_W'(1);
        tick_q <= 1'b0;
        busy_q <= 1'b1;
      end
    end

    assign tick[i] = tick_q;
    assign busy[i] = busy_q;
  end

endmodule
